// File: rtl/fetch_pkg.sv
// Shared encodings and default widths for the instruction fetch controller.
package fetch_pkg;

    localparam int               ADDR_WIDTH_DEF = 16;
    localparam int               DATA_WIDTH_DEF = 32;
    localparam logic [15:0]      RESET_PC_DEF   = 16'h0000;
    localparam int               WAIT_WIDTH     = 4;
    localparam int               COUNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        VALID  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_controller.sv
// Owns the PC, sequences the combinational instruction memory and hands each
// fetched word to decode over a valid/ready handshake.
//
// state  | meaning
// FETCH  | address held on memory, counting down wait_cnt before sampling
// VALID  | ir/ir_pc hold an undelivered instruction
// HALTED | parked at an instruction boundary, pc frozen
module instruction_fetch_controller
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEF[ADDR_WIDTH-1:0],
    parameter int                    PC_STEP     = 1,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_WIDTH-1:0]  inst_address,
    input  logic [DATA_WIDTH-1:0]  read_data,
    output logic [DATA_WIDTH-1:0]  ir,
    output logic [ADDR_WIDTH-1:0]  ir_pc,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   halt,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    localparam logic [WAIT_WIDTH-1:0] WAIT_RELOAD = WAIT_WIDTH'(WAIT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_INC      = ADDR_WIDTH'(PC_STEP);

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  handshake;
    logic                  fetch_done;

    assign inst_address = pc;
    assign handshake    = (state == VALID) && ir_ready;
    assign fetch_done   = (state == FETCH) && (wait_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (fetch_done) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                if (handshake) begin
                    state_next = halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
        // A redirect only leaves HALTED once halt has been released.
        if (redirect_valid) begin
            state_next = (state == HALTED && halt) ? HALTED : FETCH;
        end
    end

    always_comb begin
        ir_valid = 1'b0;
        halted   = 1'b0;
        case (state)
            VALID:   ir_valid = 1'b1;
            HALTED:  halted   = 1'b1;
            default: begin
                ir_valid = 1'b0;
                halted   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            wait_cnt <= WAIT_RELOAD;
            ir       <= '0;
            ir_pc    <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            wait_cnt <= WAIT_RELOAD;
        end else begin
            case (state)
                FETCH: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        ir       <= read_data;
                        ir_pc    <= pc;
                        pc       <= pc + PC_INC;
                        wait_cnt <= WAIT_RELOAD;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        wait_cnt <= WAIT_RELOAD;
                    end
                end
                default: begin
                    wait_cnt <= wait_cnt;
                end
            endcase
        end
    end

    // Handshakes count even when a redirect lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (handshake) begin
            fetch_count <= fetch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller with a small combinational
// instruction memory model (nine known words, address-derived pattern elsewhere).
module tb_instruction_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst_address;
    logic [31:0] read_data;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic [15:0] fetch_count;

    int tests_run;
    int tests_failed;
    int exp_cnt;
    int n;

    instruction_fetch_controller #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .RESET_PC   (16'h0000),
        .PC_STEP    (1),
        .WAIT_CYCLES(1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_address  (inst_address),
        .read_data     (read_data),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'd0:   mem_word = 32'h1000_0001;
            16'd1:   mem_word = 32'h2000_0012;
            16'd2:   mem_word = 32'h3000_0023;
            16'd3:   mem_word = 32'h4000_0034;
            16'd4:   mem_word = 32'h5000_0045;
            16'd5:   mem_word = 32'h6000_0056;
            16'd6:   mem_word = 32'h7000_0067;
            16'd7:   mem_word = 32'h8000_0078;
            16'd8:   mem_word = 32'h9000_0089;
            default: mem_word = {16'hDEAD, a};
        endcase
    endfunction

    assign read_data = mem_word(inst_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Ticks until ir_valid is seen at a falling edge; returns the tick count.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!ir_valid && cnt < 20);
        check_eq("valid_timeout", ir_valid, 1'b1);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        exp_cnt        = 0;
        rst_n          = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        halt           = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_addr",     inst_address, 16'h0000);
        check_eq("rst_valid",    ir_valid,     1'b0);
        check_eq("rst_ir",       ir,           32'h0);
        check_eq("rst_ir_pc",    ir_pc,        16'h0000);
        check_eq("rst_count",    fetch_count,  16'h0000);
        check_eq("rst_halted",   halted,       1'b0);

        // Straight-line fetch of addresses 0..8, one handshake every 2 cycles
        rst_n    = 1'b1;
        ir_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wait_valid(n);
            check_eq("line_latency", n, 1);
            check_eq("line_ir",      ir,    mem_word(16'(i)));
            check_eq("line_ir_pc",   ir_pc, 16'(i));
            tick();
            exp_cnt++;
            check_eq("line_count",   fetch_count, 16'(exp_cnt));
        end
        check_eq("line_count_9", fetch_count, 16'd9);

        // Backpressure at addr 3; redirect lands on a FETCH completion cycle
        ir_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0003;
        tick();
        redirect_valid = 1'b0;
        check_eq("bp_redir_addr", inst_address, 16'h0003);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_ir",    ir,           mem_word(16'h0003));
            check_eq("bp_ir_pc", ir_pc,        16'h0003);
            check_eq("bp_addr",  inst_address, 16'h0004);
            check_eq("bp_count", fetch_count,  16'(exp_cnt));
            check_eq("bp_valid", ir_valid,     1'b1);
            tick();
        end
        ir_ready = 1'b1;
        tick();
        exp_cnt++;
        ir_ready = 1'b0;
        tick();
        tick();
        check_eq("bp_one_inc", fetch_count, 16'(exp_cnt));
        check_eq("bp_next_pc", ir_pc, 16'h0004);

        // Redirect discards an undelivered word
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0002;
        tick();
        redirect_valid = 1'b0;
        check_eq("rd_drop_valid", ir_valid, 1'b0);
        wait_valid(n);
        check_eq("rd_ir_pc2", ir_pc, 16'h0002);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0006;
        tick();
        redirect_valid = 1'b0;
        check_eq("rd_valid_drop", ir_valid,    1'b0);
        check_eq("rd_not_counted", fetch_count, 16'(exp_cnt));
        wait_valid(n);
        check_eq("rd_ir6",    ir,    mem_word(16'h0006));
        check_eq("rd_ir_pc6", ir_pc, 16'h0006);
        check_eq("rd_count",  fetch_count, 16'(exp_cnt));

        // Redirect coincident with a handshake still counts it
        ir_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0006;
        tick();
        exp_cnt++;
        check_eq("rdhs_count", fetch_count, 16'(exp_cnt));
        check_eq("rdhs_valid", ir_valid,    1'b0);
        check_eq("rdhs_addr",  inst_address, 16'h0006);

        // Halt raised during FETCH of addr 4
        redirect_pc = 16'h0004;
        ir_ready    = 1'b0;
        tick();
        redirect_valid = 1'b0;
        halt           = 1'b1;
        ir_ready       = 1'b1;
        tick();
        check_eq("halt_deliver_v",  ir_valid, 1'b1);
        check_eq("halt_deliver_pc", ir_pc,    16'h0004);
        tick();
        exp_cnt++;
        for (int i = 0; i < 10; i++) begin
            check_eq("halt_halted", halted,       1'b1);
            check_eq("halt_valid",  ir_valid,     1'b0);
            check_eq("halt_addr",   inst_address, 16'h0005);
            tick();
        end
        check_eq("halt_count", fetch_count, 16'(exp_cnt));
        halt = 1'b0;
        wait_valid(n);
        check_eq("unhalt_latency", n, 2);
        check_eq("unhalt_ir_pc",   ir_pc, 16'h0005);
        check_eq("unhalt_ir",      ir,    mem_word(16'h0005));
        halt = 1'b1;
        tick();
        exp_cnt++;
        check_eq("halt2_halted", halted,       1'b1);
        check_eq("halt2_addr",   inst_address, 16'h0006);

        // Redirect while halted with halt held: pc moves, state stays parked
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0007;
        tick();
        redirect_valid = 1'b0;
        check_eq("hredir_halted", halted,       1'b1);
        check_eq("hredir_addr",   inst_address, 16'h0007);
        halt = 1'b0;
        wait_valid(n);
        check_eq("hredir_ir_pc", ir_pc, 16'h0007);
        check_eq("hredir_ir",    ir,    mem_word(16'h0007));
        tick();
        exp_cnt++;

        // PC wrap from FFFF to 0000
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        wait_valid(n);
        check_eq("wrap_ir_pc", ir_pc, 16'hFFFF);
        check_eq("wrap_ir",    ir,    32'hDEAD_FFFF);
        tick();
        exp_cnt++;
        check_eq("wrap_addr", inst_address, 16'h0000);
        wait_valid(n);
        check_eq("wrap_next_pc", ir_pc, 16'h0000);
        check_eq("wrap_next_ir", ir,    mem_word(16'h0000));
        tick();
        exp_cnt++;
        check_eq("wrap_count", fetch_count, 16'(exp_cnt));

        // Async reset between edges while VALID
        ir_ready = 1'b0;
        wait_valid(n);
        check_eq("ar_pre_valid", ir_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid",  ir_valid,     1'b0);
        check_eq("ar_ir",     ir,           32'h0);
        check_eq("ar_count",  fetch_count,  16'h0000);
        check_eq("ar_halted", halted,       1'b0);
        check_eq("ar_addr",   inst_address, 16'h0000);
        tick();
        rst_n    = 1'b1;
        ir_ready = 1'b1;
        wait_valid(n);
        check_eq("ar_restart_pc", ir_pc, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
